// File: rtl/multdiv_defs.sv
// Shared definitions for the iterative multiply/divide unit.
//   DefaultWidth : default operand/result width (also the iteration count)
//   state_e      : control FSM state encodings
//   op_e         : datapath operation select
package multdiv_defs;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDiv  = 2'b10,
        StDone = 2'b11
    } state_e;

    typedef enum logic {
        OpMul = 1'b0,
        OpDiv = 1'b1
    } op_e;

endpackage

// File: rtl/multdiv_datapath.sv
// Step registers shared by the radix-2 Booth multiplier and the non-restoring divider.
//   clk, rst       : clock, synchronous active-high reset
//   load           : latch operands and operation, clear the accumulator
//   step           : perform one add/sub-shift iteration
//   op             : operation to latch on load
//   load_m         : multiplicand (mul) or divisor magnitude (div)
//   load_lo        : multiplier (mul) or dividend magnitude (div)
//   product_next   : full 2*WIDTH product as it will be after the current step
//   quotient_next  : quotient as it will be after the current step
module multdiv_datapath
    import multdiv_defs::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  op_e                  op,
    input  logic [WIDTH-1:0]     load_m,
    input  logic [WIDTH-1:0]     load_lo,
    output logic [2*WIDTH-1:0]   product_next,
    output logic [WIDTH-1:0]     quotient_next
);

    // acc holds the Booth upper half (low WIDTH bits used) or the signed partial remainder.
    // The remainder spans [-D, D) with D up to 2^(WIDTH-1), so the shifted form needs WIDTH+2.
    logic [WIDTH+1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q;
    logic             booth_q, booth_d;
    op_e              op_q;

    logic [WIDTH:0]   hi_ext, m_ext, booth_sum;
    logic [WIDTH+1:0] shifted, div_ext, rem_next;

    always_comb begin
        // Booth: add/sub in WIDTH+1 bits so that subtracting the most negative
        // multiplicand cannot overflow before the arithmetic shift.
        hi_ext = {acc_q[WIDTH-1], acc_q[WIDTH-1:0]};
        m_ext  = {m_q[WIDTH-1], m_q};
        case ({lo_q[0], booth_q})
            2'b01:   booth_sum = hi_ext + m_ext;
            2'b10:   booth_sum = hi_ext - m_ext;
            default: booth_sum = hi_ext;
        endcase

        // Non-restoring: shift the next dividend bit in, then subtract when the
        // remainder is non-negative, add back when it is negative.
        shifted  = {acc_q[WIDTH:0], lo_q[WIDTH-1]};
        div_ext  = {2'b00, m_q};
        rem_next = acc_q[WIDTH+1] ? (shifted + div_ext) : (shifted - div_ext);

        if (op_q == OpDiv) begin
            acc_d   = rem_next;
            lo_d    = {lo_q[WIDTH-2:0], ~rem_next[WIDTH+1]};
            booth_d = 1'b0;
        end else begin
            acc_d   = {{2{booth_sum[WIDTH]}}, booth_sum[WIDTH:1]};
            lo_d    = {booth_sum[0], lo_q[WIDTH-1:1]};
            booth_d = lo_q[0];
        end
    end

    assign product_next  = {acc_d[WIDTH-1:0], lo_d};
    assign quotient_next = lo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            booth_q <= 1'b0;
            op_q    <= OpMul;
        end else if (load) begin
            acc_q   <= '0;
            lo_q    <= load_lo;
            m_q     <= load_m;
            booth_q <= 1'b0;
            op_q    <= op;
        end else if (step) begin
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            booth_q <= booth_d;
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : abort the in-flight operation without a result
//   ctrl_mult       : start multiply (wins when both starts are high)
//   ctrl_div        : start divide
//   data_operandA   : multiplicand / dividend
//   data_operandB   : multiplier / divisor
//   data_result     : low product bits / truncated quotient, held until the next result
//   data_exception  : overflow or divide-by-zero, valid with data_resultRDY
//   data_resultRDY  : one-cycle result-valid pulse
//   busy            : operation in flight, stalls the front of the pipeline
module multdiv_unit
    import multdiv_defs::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned     CntW      = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MinVal   = {1'b1, {(WIDTH - 1){1'b0}}};

    state_e          state_q;
    logic [CntW-1:0] count_q;
    logic            neg_q;
    logic            div0_q;
    logic            ovf_q;
    logic [WIDTH-1:0] result_q;
    logic            exc_q;
    logic            rdy_q;
    logic            busy_q;

    logic             start_req, load, step, running;
    op_e              start_op;
    logic [WIDTH-1:0] mag_a, mag_b, load_m, load_lo;
    logic [2*WIDTH-1:0] product_next;
    logic [WIDTH-1:0] quotient_next;
    logic [WIDTH:0]   prod_top;
    logic             mul_ovf;
    logic [WIDTH-1:0] quot_signed;

    always_comb begin
        start_req = ctrl_mult | ctrl_div;
        start_op  = ctrl_mult ? OpMul : OpDiv;
        running   = (state_q == StMul) || (state_q == StDiv);
        // Flush beats a start; a start beats continuing the current op.
        load      = start_req & ~flush;
        step      = running & ~load & ~flush;

        mag_a   = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        mag_b   = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
        load_m  = (start_op == OpDiv) ? mag_b : data_operandA;
        load_lo = (start_op == OpDiv) ? mag_a : data_operandB;

        // The product fits WIDTH bits only if bits 2W-1..W-1 are all equal.
        prod_top    = product_next[2*WIDTH-1:WIDTH-1];
        mul_ovf     = ~((&prod_top) | ~(|prod_top));
        quot_signed = neg_q ? (~quotient_next + 1'b1) : quotient_next;
    end

    multdiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .step          (step),
        .op            (start_op),
        .load_m        (load_m),
        .load_lo       (load_lo),
        .product_next  (product_next),
        .quotient_next (quotient_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (flush) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else if (start_req) begin
                state_q <= (start_op == OpMul) ? StMul : StDiv;
                count_q <= '0;
                busy_q  <= 1'b1;
                exc_q   <= 1'b0;
                neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div0_q  <= (data_operandB == '0);
                ovf_q   <= (data_operandA == MinVal) && (data_operandB == '1);
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StMul, StDiv: begin
                        count_q <= count_q + 1'b1;
                        // The last step's outcome is taken straight from the datapath
                        // so the result registers together with the DONE transition.
                        if (count_q == LastCount) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            rdy_q   <= 1'b1;
                            if (state_q == StMul) begin
                                result_q <= product_next[WIDTH-1:0];
                                exc_q    <= mul_ovf;
                            end else if (div0_q) begin
                                result_q <= '0;
                                exc_q    <= 1'b1;
                            end else begin
                                result_q <= quot_signed;
                                exc_q    <= ovf_q;
                            end
                        end
                    end
                    StDone: state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;

    multdiv_unit #(
        .WIDTH (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .ctrl_mult      (ctrl_mult),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a start for one cycle; returns at the negedge of cycle 1.
    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ctrl_mult     = m;
        ctrl_div      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clk);
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
    endtask

    // Observe 60 cycles starting at cycle start_cyc (bounded, never hangs).
    task automatic run_obs(input int start_cyc, output int rdy_cyc, output int n_rdy,
                           output int busy_n, output int busy_last,
                           output logic [31:0] res, output logic exc);
        rdy_cyc   = -1;
        n_rdy     = 0;
        busy_n    = 0;
        busy_last = -1;
        res       = 'x;
        exc       = 1'bx;
        for (int i = 0; i < 60; i++) begin
            if (busy) begin
                busy_n++;
                busy_last = start_cyc + i;
            end
            if (data_resultRDY) begin
                n_rdy++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = start_cyc + i;
                    res     = data_result;
                    exc     = data_exception;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic op_check(input string tag, input logic m, input logic d,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic exp_exc);
        int rc, nr, bn, bl;
        logic [31:0] r;
        logic e;
        start(m, d, a, b);
        run_obs(1, rc, nr, bn, bl, r, e);
        check({tag, "/rdy_cycle"}, 32'(rc), 32'd33);
        check({tag, "/rdy_count"}, 32'(nr), 32'd1);
        check({tag, "/busy_cycles"}, 32'(bn), 32'd32);
        check({tag, "/busy_last"}, 32'(bl), 32'd32);
        check({tag, "/result"}, r, exp_res);
        check({tag, "/exception"}, {31'd0, e}, {31'd0, exp_exc});
    endtask

    int rc, nr, bn, bl;
    logic [31:0] r;
    logic e;

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        ctrl_mult     = 1'b0;
        ctrl_div      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clk);
        check("reset/result", data_result, 32'd0);
        check("reset/exception", {31'd0, data_exception}, 32'd0);
        check("reset/rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset/busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        op_check("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        op_check("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        op_check("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        op_check("div_by0", 1'b0, 1'b1, 32'd5, 32'd0, 32'h0000_0000, 1'b1);
        op_check("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        op_check("both_ctrl", 1'b1, 1'b1, 32'd5, 32'd6, 32'd30, 1'b0);
        op_check("mul_min_m1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        op_check("mul_m1_m1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
        op_check("div_0_5", 1'b0, 1'b1, 32'd0, 32'd5, 32'd0, 1'b0);
        op_check("div_m100_m7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);

        // Start accepted in the DONE cycle; the completing op still reports.
        start(1'b1, 1'b0, 32'd2, 32'd3);
        repeat (32) @(negedge clk);
        check("done_start/old_rdy", {31'd0, data_resultRDY}, 32'd1);
        check("done_start/old_result", data_result, 32'd6);
        ctrl_div      = 1'b1;
        data_operandA = 32'hFFFF_FFEC;
        data_operandB = 32'd3;
        @(negedge clk);
        ctrl_div = 1'b0;
        check("done_start/busy", {31'd0, busy}, 32'd1);
        check("done_start/rdy_low", {31'd0, data_resultRDY}, 32'd0);
        run_obs(34, rc, nr, bn, bl, r, e);
        check("done_start/rdy_cycle", 32'(rc), 32'd66);
        check("done_start/rdy_count", 32'(nr), 32'd1);
        check("done_start/result", r, 32'hFFFF_FFFA);

        // Flush at cycle 10 of a multiply.
        start(1'b1, 1'b0, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush/busy", {31'd0, busy}, 32'd0);
        run_obs(11, rc, nr, bn, bl, r, e);
        check("flush/rdy_count", 32'(nr), 32'd0);
        check("flush/busy_cycles", 32'(bn), 32'd0);
        check("flush/result_held", data_result, 32'hFFFF_FFFA);

        // Restart with a multiply at cycle 5 of a divide.
        start(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        ctrl_mult     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        @(negedge clk);
        ctrl_mult = 1'b0;
        run_obs(6, rc, nr, bn, bl, r, e);
        check("restart/rdy_cycle", 32'(rc), 32'd38);
        check("restart/rdy_count", 32'(nr), 32'd1);
        check("restart/result", r, 32'd12);
        check("restart/exception", {31'd0, e}, 32'd0);

        // Reset at cycle 20 of a multiply.
        start(1'b1, 1'b0, 32'd11, 32'd13);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst/result", data_result, 32'd0);
        check("midrst/exception", {31'd0, data_exception}, 32'd0);
        check("midrst/rdy", {31'd0, data_resultRDY}, 32'd0);
        check("midrst/busy", {31'd0, busy}, 32'd0);
        run_obs(21, rc, nr, bn, bl, r, e);
        check("midrst/rdy_count", 32'(nr), 32'd0);
        op_check("div_9_3", 1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
